// File: rtl/rvfi_order_sorter_pkg.sv
// Shared types for the RVFI order sorter: buffered retirement payload and
// the per-channel input classification result.
package rvfi_order_sorter_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [31:0]     insn;
    logic            trap;
  } entry_t;

  typedef enum logic [1:0] {
    CLS_OK     = 2'd0,
    CLS_STALE  = 2'd1,
    CLS_WINDOW = 2'd2,
    CLS_DUP    = 2'd3
  } cls_t;

endpackage

// File: rtl/rvfi_order_sorter_classify.sv
// Combinational classification of one input channel against the reorder
// window; priority stale > window > dup.
module rvfi_order_classify
  import rvfi_order_sorter_pkg::*;
#(
  parameter int NRET       = 2,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int CH         = 0
) (
  input  logic [63:0]        i_order,
  input  logic [63:0]        i_next_order,
  input  logic [DEPTH-1:0]   i_slot_valid,
  input  logic [64*NRET-1:0] i_all_order,
  input  logic [NRET-1:0]    i_all_valid,
  output cls_t               o_cls
);

  logic [63:0] w_dist;
  logic        w_lower_hit;

  // Distance into the window and same-cycle collision with lower channels.
  always_comb begin
    w_dist      = i_order - i_next_order;
    w_lower_hit = 1'b0;
    for (int j = 0; j < CH; j++) begin
      if (i_all_valid[j] && (i_all_order[64*j +: 64] == i_order)) begin
        w_lower_hit = 1'b1;
      end else begin
        w_lower_hit = w_lower_hit;
      end
    end
    // Stale is tested first, so w_dist never wraps when the window test runs.
    if (i_order < i_next_order) begin
      o_cls = CLS_STALE;
    end else if (w_dist >= 64'(DEPTH)) begin
      o_cls = CLS_WINDOW;
    end else if (i_slot_valid[i_order[LOG2_DEPTH-1:0]] || w_lower_hit) begin
      o_cls = CLS_DUP;
    end else begin
      o_cls = CLS_OK;
    end
  end

endmodule

// File: rtl/rvfi_order_sorter.sv
// Reorders up to NRET RVFI retirements per cycle into one strictly ascending
// output stream, one entry per cycle, with sticky protocol error flags.
module rvfi_order_sorter
  import rvfi_order_sorter_pkg::*;
#(
  parameter int XLEN       = rvfi_order_sorter_pkg::XLEN,
  parameter int NRET       = 2,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NRET-1:0]      in_valid,
  input  logic [64*NRET-1:0]   in_order,
  input  logic [XLEN*NRET-1:0] in_pc_rdata,
  input  logic [XLEN*NRET-1:0] in_pc_wdata,
  input  logic [32*NRET-1:0]   in_insn,
  input  logic [NRET-1:0]      in_trap,
  output logic                 out_valid,
  output logic [63:0]          out_order,
  output logic [XLEN-1:0]      out_pc_rdata,
  output logic [XLEN-1:0]      out_pc_wdata,
  output logic [31:0]          out_insn,
  output logic                 out_trap,
  output logic [LOG2_DEPTH:0]  occupancy,
  output logic                 err_stale,
  output logic                 err_window,
  output logic                 err_dup
);

  entry_t                r_slot [DEPTH];
  entry_t                w_slot_nxt [DEPTH];
  logic [DEPTH-1:0]      r_slot_valid;
  logic [DEPTH-1:0]      w_slot_valid_nxt;
  logic [63:0]           r_next_order;
  logic [LOG2_DEPTH:0]   r_occupancy;
  logic [LOG2_DEPTH:0]   w_accept_cnt;
  entry_t                r_out;
  logic                  r_out_valid;
  logic                  r_err_stale;
  logic                  r_err_window;
  logic                  r_err_dup;
  cls_t                  w_cls [NRET];
  entry_t                w_in [NRET];
  logic [NRET-1:0]       w_accept;
  logic [NRET-1:0]       w_stale;
  logic [NRET-1:0]       w_window;
  logic [NRET-1:0]       w_dup;
  logic [LOG2_DEPTH-1:0] w_head;
  logic                  w_drain;

  for (genvar i = 0; i < NRET; i++) begin : g_ch
    rvfi_order_classify #(
      .NRET      (NRET),
      .DEPTH     (DEPTH),
      .LOG2_DEPTH(LOG2_DEPTH),
      .CH        (i)
    ) u_classify (
      .i_order     (in_order[64*i +: 64]),
      .i_next_order(r_next_order),
      .i_slot_valid(r_slot_valid),
      .i_all_order (in_order),
      .i_all_valid (in_valid),
      .o_cls       (w_cls[i])
    );

    assign w_in[i] = '{order:    in_order[64*i +: 64],
                       pc_rdata: in_pc_rdata[XLEN*i +: XLEN],
                       pc_wdata: in_pc_wdata[XLEN*i +: XLEN],
                       insn:     in_insn[32*i +: 32],
                       trap:     in_trap[i]};
    assign w_accept[i] = in_valid[i] && (w_cls[i] == CLS_OK);
    assign w_stale[i]  = in_valid[i] && (w_cls[i] == CLS_STALE);
    assign w_window[i] = in_valid[i] && (w_cls[i] == CLS_WINDOW);
    assign w_dup[i]    = in_valid[i] && (w_cls[i] == CLS_DUP);
  end

  assign w_head  = r_next_order[LOG2_DEPTH-1:0];
  assign w_drain = r_slot_valid[w_head];

  // Next slot contents: clear the drained head, then land accepted entries.
  // An accepted entry can never target the head slot (it would be dup).
  always_comb begin
    w_slot_valid_nxt = r_slot_valid;
    w_slot_nxt       = r_slot;
    w_accept_cnt     = '0;
    if (w_drain) begin
      w_slot_valid_nxt[w_head] = 1'b0;
    end else begin
      w_slot_valid_nxt[w_head] = r_slot_valid[w_head];
    end
    for (int i = 0; i < NRET; i++) begin
      if (w_accept[i]) begin
        w_slot_valid_nxt[w_in[i].order[LOG2_DEPTH-1:0]] = 1'b1;
        w_slot_nxt[w_in[i].order[LOG2_DEPTH-1:0]]       = w_in[i];
        w_accept_cnt = w_accept_cnt + (LOG2_DEPTH+1)'(1);
      end else begin
        w_accept_cnt = w_accept_cnt;
      end
    end
  end

  // Slot storage, head order counter and occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_slot_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_slot[k] <= '0;
      end
      r_next_order <= 64'd0;
      r_occupancy  <= '0;
    end else begin
      r_slot_valid <= w_slot_valid_nxt;
      r_slot       <= w_slot_nxt;
      r_next_order <= r_next_order + 64'(w_drain);
      r_occupancy  <= r_occupancy + w_accept_cnt - (LOG2_DEPTH+1)'(w_drain);
    end
  end

  // Output register and sticky error flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_err_stale  <= 1'b0;
      r_err_window <= 1'b0;
      r_err_dup    <= 1'b0;
    end else begin
      r_out_valid <= w_drain;
      if (w_drain) begin
        r_out <= r_slot[w_head];
      end else begin
        r_out <= r_out;
      end
      r_err_stale  <= r_err_stale  | (|w_stale);
      r_err_window <= r_err_window | (|w_window);
      r_err_dup    <= r_err_dup    | (|w_dup);
    end
  end

  assign out_valid    = r_out_valid;
  assign out_order    = r_out.order;
  assign out_pc_rdata = r_out.pc_rdata;
  assign out_pc_wdata = r_out.pc_wdata;
  assign out_insn     = r_out.insn;
  assign out_trap     = r_out.trap;
  assign occupancy    = r_occupancy;
  assign err_stale    = r_err_stale;
  assign err_window   = r_err_window;
  assign err_dup      = r_err_dup;

endmodule

// File: tb/tb_rvfi_order_sorter.sv
// Directed self-checking bench for rvfi_order_sorter: inputs change and
// outputs are sampled on the falling clock edge.
module tb_rvfi_order_sorter;

  localparam int XLEN       = 32;
  localparam int NRET       = 2;
  localparam int DEPTH      = 8;
  localparam int LOG2_DEPTH = 3;

  logic                 clock = 1'b0;
  logic                 resetn = 1'b0;
  logic [NRET-1:0]      in_valid;
  logic [64*NRET-1:0]   in_order;
  logic [XLEN*NRET-1:0] in_pc_rdata;
  logic [XLEN*NRET-1:0] in_pc_wdata;
  logic [32*NRET-1:0]   in_insn;
  logic [NRET-1:0]      in_trap;
  logic                 out_valid;
  logic [63:0]          out_order;
  logic [XLEN-1:0]      out_pc_rdata;
  logic [XLEN-1:0]      out_pc_wdata;
  logic [31:0]          out_insn;
  logic                 out_trap;
  logic [LOG2_DEPTH:0]  occupancy;
  logic                 err_stale;
  logic                 err_window;
  logic                 err_dup;

  int n_cmp = 0;
  int n_err = 0;

  rvfi_order_sorter #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_order(in_order), .in_pc_rdata(in_pc_rdata),
    .in_pc_wdata(in_pc_wdata), .in_insn(in_insn), .in_trap(in_trap),
    .out_valid(out_valid), .out_order(out_order), .out_pc_rdata(out_pc_rdata),
    .out_pc_wdata(out_pc_wdata), .out_insn(out_insn), .out_trap(out_trap),
    .occupancy(occupancy), .err_stale(err_stale), .err_window(err_window),
    .err_dup(err_dup)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] ord,
                         input logic [LOG2_DEPTH:0] occ);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_order"}, out_order, ord);
    chk({tag, "_occ"}, 64'(occupancy), 64'(occ));
  endtask

  task automatic chk_err(input string tag, input logic [2:0] exp);
    chk({tag, "_err"}, 64'({err_stale, err_window, err_dup}), 64'(exp));
  endtask

  task automatic idle();
    in_valid    = '0;
    in_order    = '0;
    in_pc_rdata = '0;
    in_pc_wdata = '0;
    in_insn     = '0;
    in_trap     = '0;
  endtask

  // Payload convention: pc_wdata = pc+4, insn = 0x13 + order, trap = order[0].
  task automatic put(input int ch, input logic [63:0] ord, input logic [31:0] pc);
    in_valid[ch]                 = 1'b1;
    in_order[64*ch +: 64]        = ord;
    in_pc_rdata[XLEN*ch +: XLEN] = pc;
    in_pc_wdata[XLEN*ch +: XLEN] = pc + 32'd4;
    in_insn[32*ch +: 32]         = 32'h0000_0013 + ord[31:0];
    in_trap[ch]                  = ord[0];
  endtask

  task automatic tick();
    @(negedge clock);
    idle();
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    chk_out("rst", 1'b0, 64'd0, 4'd0);
    chk("rst_pc", 64'(out_pc_rdata), 64'd0);
    chk_err("rst", 3'b000);

    // In-order single channel.
    put(0, 64'd0, 32'h100); tick(); chk_out("t1_c0", 1'b0, 64'd0, 4'd1);
    put(0, 64'd1, 32'h104); tick(); chk_out("t1_c1", 1'b1, 64'd0, 4'd1);
    put(0, 64'd2, 32'h108); tick(); chk_out("t1_c2", 1'b1, 64'd1, 4'd1);
    put(0, 64'd3, 32'h10c); tick(); chk_out("t1_c3", 1'b1, 64'd2, 4'd1);
    tick(); chk_out("t1_c4", 1'b1, 64'd3, 4'd0);
    chk("t1_pc", 64'(out_pc_rdata), 64'h10c);
    tick(); chk_out("t1_c5", 1'b0, 64'd3, 4'd0);

    // Reversed pair in one cycle.
    do_reset();
    put(0, 64'd1, 32'h104); put(1, 64'd0, 32'h100);
    tick(); chk_out("t2_a", 1'b0, 64'd0, 4'd2);
    tick(); chk_out("t2_b", 1'b1, 64'd0, 4'd1);
    chk("t2_b_pc", 64'(out_pc_rdata), 64'h100);
    chk("t2_b_pcw", 64'(out_pc_wdata), 64'h104);
    chk("t2_b_insn", 64'(out_insn), 64'h13);
    chk("t2_b_trap", 64'(out_trap), 64'd0);
    tick(); chk_out("t2_c", 1'b1, 64'd1, 4'd0);
    chk("t2_c_pc", 64'(out_pc_rdata), 64'h104);
    chk("t2_c_trap", 64'(out_trap), 64'd1);
    chk_err("t2", 3'b000);

    // Gap stall: 1,2,3 buffered while 0 is withheld.
    do_reset();
    put(0, 64'd1, 32'h104); put(1, 64'd2, 32'h108); tick();
    put(0, 64'd3, 32'h10c); tick(); chk_out("t3_fill", 1'b0, 64'd0, 4'd3);
    for (int c = 0; c < 5; c++) begin
      tick(); chk_out("t3_stall", 1'b0, 64'd0, 4'd3);
    end
    put(0, 64'd0, 32'h100); tick(); chk_out("t3_arr", 1'b0, 64'd0, 4'd4);
    for (int k = 0; k < 4; k++) begin
      tick(); chk_out("t3_drain", 1'b1, 64'(k), 4'(3 - k));
    end
    chk_err("t3", 3'b000);

    // Window and stale.
    do_reset();
    put(0, 64'd8, 32'h120); put(1, 64'd7, 32'h11c);
    tick(); chk_out("t4_win", 1'b0, 64'd0, 4'd1); chk_err("t4_win", 3'b010);
    put(0, 64'd0, 32'h100); tick(); chk_out("t4_c1", 1'b0, 64'd0, 4'd2);
    tick(); chk_out("t4_c2", 1'b1, 64'd0, 4'd1); chk_err("t4_c2", 3'b010);
    put(0, 64'd0, 32'h200); tick(); chk_out("t4_stale", 1'b0, 64'd0, 4'd1);
    chk_err("t4_stale", 3'b110);
    chk("t4_pc_held", 64'(out_pc_rdata), 64'h100);
    put(0, 64'd8, 32'h120); tick(); chk_out("t4_edge", 1'b0, 64'd0, 4'd2);
    chk_err("t4_edge", 3'b110);

    // Duplicates: same cycle, then against a buffered slot.
    do_reset();
    put(0, 64'd5, 32'h500); put(1, 64'd5, 32'h5f0);
    tick(); chk_out("t5_a", 1'b0, 64'd0, 4'd1); chk_err("t5_a", 3'b001);
    put(0, 64'd5, 32'h770); tick(); chk_out("t5_b", 1'b0, 64'd0, 4'd1);
    chk_err("t5_b", 3'b001);
    put(0, 64'd0, 32'h100); put(1, 64'd1, 32'h104); tick();
    chk_out("t5_c", 1'b0, 64'd0, 4'd3);
    put(0, 64'd2, 32'h108); put(1, 64'd3, 32'h10c); tick();
    chk_out("t5_d", 1'b1, 64'd0, 4'd4);
    put(0, 64'd4, 32'h110); tick(); chk_out("t5_e", 1'b1, 64'd1, 4'd4);
    tick(); chk_out("t5_f", 1'b1, 64'd2, 4'd3);
    tick(); chk_out("t5_g", 1'b1, 64'd3, 4'd2);
    tick(); chk_out("t5_h", 1'b1, 64'd4, 4'd1);
    tick(); chk_out("t5_i", 1'b1, 64'd5, 4'd0);
    chk("t5_pc", 64'(out_pc_rdata), 64'h500);
    chk_err("t5_end", 3'b001);

    // Reset mid-operation with four entries buffered.
    put(0, 64'd7, 32'h11c); put(1, 64'd8, 32'h120); tick();
    chk_out("t6_a", 1'b0, 64'd5, 4'd2);
    put(0, 64'd6, 32'h118); put(1, 64'd9, 32'h124); tick();
    chk_out("t6_b", 1'b0, 64'd5, 4'd4);
    put(0, 64'd10, 32'h128); tick(); chk_out("t6_c", 1'b1, 64'd6, 4'd4);
    #2 resetn = 1'b0;
    #1 chk_out("t6_rst", 1'b0, 64'd0, 4'd0);
    chk("t6_rst_pc", 64'(out_pc_rdata), 64'd0);
    chk_err("t6_rst", 3'b000);
    tick();
    resetn = 1'b1;
    put(0, 64'd1, 32'h104); tick(); chk_out("t6_d", 1'b0, 64'd0, 4'd1);
    tick(); chk_out("t6_e", 1'b0, 64'd0, 4'd1);
    put(0, 64'd0, 32'h100); tick(); chk_out("t6_f", 1'b0, 64'd0, 4'd2);
    tick(); chk_out("t6_g", 1'b1, 64'd0, 4'd1);
    tick(); chk_out("t6_h", 1'b1, 64'd1, 4'd0);
    chk_err("t6_end", 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
